univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register length in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: clock enable; when 0, all state holds.
REQ-005 The block SHALL have port mode, input, 2 bits: manual operation select; 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have port sin_r, input, 1 bit: serial bit entering the MSB on a right shift.
REQ-007 The block SHALL have port sin_l, input, 1 bit: serial bit entering the LSB on a left shift.
REQ-008 The block SHALL have port pin, input, WIDTH bits: parallel load data.
REQ-009 The block SHALL have port start, input, 1 bit: request for an automatic burst shift-out.
REQ-010 The block SHALL have port dir, input, 1 bit: burst direction, sampled with start; 0 right (LSB first), 1 left (MSB first).
REQ-011 The block SHALL have port q, output, WIDTH bits: register contents (parallel out).
REQ-012 The block SHALL have port sout_r, output, 1 bit: equal to q[0].
REQ-013 The block SHALL have port sout_l, output, 1 bit: equal to q[WIDTH-1].
REQ-014 The block SHALL have port sout_valid, output, 1 bit: high in every burst SHIFT cycle.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: a single-cycle pulse at the end of a burst.

Function
REQ-017 The block SHALL implement three FSM states: IDLE, SHIFT and DONE; every transition SHALL occur only on a clk edge with en=1.
REQ-018 In IDLE, the register SHALL follow mode: hold keeps q; shift right gives q <= {sin_r, q[WIDTH-1:1]}; shift left gives q <= {q[WIDTH-2:0], sin_l}; load gives q <= pin.
REQ-019 In IDLE with start=1, the block SHALL load q <= pin, latch dir, set cnt <= WIDTH, enter SHIFT, and ignore mode that cycle (start wins over mode).
REQ-020 In SHIFT, each enabled cycle SHALL shift once in the latched direction, filling from sin_r or sin_l, and decrement cnt.
REQ-021 The current serial bit SHALL be on sout_r (right) or sout_l (left) while sout_valid=1, before that cycle's shift.
REQ-022 In SHIFT, the block SHALL enter DONE on the edge where cnt==1, giving exactly WIDTH sout_valid cycles.
REQ-023 DONE SHALL assert done for one cycle and then return to IDLE unconditionally, leaving q holding the shifted-out result.
REQ-024 mode, start, pin and dir SHALL be ignored while busy=1; a start arriving in SHIFT or DONE SHALL be dropped, not queued.
REQ-025 With en=0 in SHIFT, the block SHALL freeze q, cnt and state; sout_valid SHALL stay high, and the same bit SHALL be presented again.
REQ-026 cnt SHALL be $clog2(WIDTH+1) bits wide and SHALL never underflow.
REQ-027 A back-to-back burst SHALL be possible: start may be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-028 While rst=0, asynchronously: q=0, cnt=0, latched dir=0, state=IDLE, busy=0, done=0, sout_valid=0, sout_r=0, sout_l=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no done pulse, and the first edge after release SHALL behave as IDLE.

Structure
REQ-030 A shared package univ_shift_pkg SHALL hold the mode encodings (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the FSM state enum.
REQ-031 One sub-module, usr_bit, SHALL be used: a per-bit 4:1 select (hold/right/left/load) feeding an async-active-low-reset flop, instantiated WIDTH times by generate.
REQ-032 The FSM and counter SHALL live in univ_shift_reg and drive the usr_bit select lines.

Verification (WIDTH=8)
REQ-033 Load then shift right: mode=11, pin=0xA5, then mode=01, sin_r=1 -> q=0xA5, then q=0xD2, sout_r=0.
REQ-034 Shift left: from q=0xA5, mode=10, sin_l=0, 2 cycles -> q=0x4A, then q=0x94, sout_l=1.
REQ-035 Right burst: start=1, dir=0, pin=0xB4 -> sout_valid high 8 cycles with sout_r=0,0,1,0,1,1,0,1; then done pulses 1 cycle; busy high for 9 cycles.
REQ-036 Left burst with en toggled 0 on the 3rd SHIFT cycle: pin=0xB4 -> sout_l=1,0,1,1,0,1,0,0 with the 3rd bit repeated during the stall; burst length 9 SHIFT cycles.
REQ-037 Start pulsed during SHIFT, and mode=11 during busy -> no effect on q or on the burst, and exactly one done pulse.
REQ-038 rst=0 asserted at SHIFT cycle 4 -> q=0 and busy=0 immediately, no done pulse; after release, mode=11 pin=0x3C -> q=0x3C.

Source files
------------

// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: manual mode select and burst FSM states.
package univ_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

endpackage

// File: rtl/usr_bit.sv
// One register bit: 4:1 select (hold/right/left/load) in front of an async active-low reset flop.
module usr_bit
    import univ_shift_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  mode_e sel_i,
    input  logic  msb_side_i,  // neighbour toward the MSB; enters on a right shift
    input  logic  lsb_side_i,  // neighbour toward the LSB; enters on a left shift
    input  logic  load_i,
    output logic  q_o
);

    logic q_d, q_q;

    always_comb begin
        q_d = q_q;
        unique case (sel_i)
            MODE_HOLD: q_d = q_q;
            MODE_SHR:  q_d = msb_side_i;
            MODE_SHL:  q_d = lsb_side_i;
            MODE_LOAD: q_d = load_i;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with manual modes and an automatic WIDTH-bit burst shift-out.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;
    mode_e           sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        sel        = MODE_HOLD;
        sout_valid = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    if (start) begin
                        sel     = MODE_LOAD;
                        dir_d   = dir;
                        cnt_d   = CntW'(WIDTH);
                        state_d = StShift;
                    end else begin
                        sel = mode_e'(mode);
                    end
                end
            end
            StShift: begin
                sout_valid = 1'b1;
                if (en) begin
                    sel = dir_q ? MODE_SHL : MODE_SHR;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                    // <= also catches a corrupted zero count so the burst can never stick
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done = 1'b1;
                if (en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic msb_side, lsb_side;
        if (i == WIDTH - 1) begin : g_top
            assign msb_side = sin_r;
        end else begin : g_mid_hi
            assign msb_side = q[i+1];
        end
        if (i == 0) begin : g_bot
            assign lsb_side = sin_l;
        end else begin : g_mid_lo
            assign lsb_side = q[i-1];
        end
        usr_bit u_bit (
            .clk_i      (clk),
            .rst_ni     (rst),
            .sel_i      (sel),
            .msb_side_i (msb_side),
            .lsb_side_i (lsb_side),
            .load_i     (pin[i]),
            .q_o        (q[i])
        );
    end

    assign busy   = (state_q != StIdle);
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: behavioural model, directed bursts, random stimulus.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk, rst, en, sin_r, sin_l, start, dir;
    logic [1:0]   mode;
    logic [W-1:0] pin, q;
    logic         sout_r, sout_l, sout_valid, busy, done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    bit obs[$];

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .start      (start),
        .dir        (dir),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: register value plus "shifts remaining" and a pending-done flag.
    logic [W-1:0] m_q = '0;
    int           m_rem = 0;
    bit           m_dir = 0;
    bit           m_done = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q = '0; m_rem = 0; m_dir = 0; m_done = 0;
        end else if (en) begin
            if (m_done) begin
                m_done = 0;
            end else if (m_rem > 0) begin
                if (m_dir) m_q = (m_q << 1) | W'(sin_l);
                else       m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
                m_rem = m_rem - 1;
                if (m_rem == 0) m_done = 1;
            end else if (start) begin
                m_q = pin; m_rem = W; m_dir = dir;
            end else begin
                case (mode)
                    2'd1: m_q = (m_q >> 1) | (W'(sin_r) << (W - 1));
                    2'd2: m_q = (m_q << 1) | W'(sin_l);
                    2'd3: m_q = pin;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q", q, m_q);
            chk("sout_r", sout_r, m_q % 2);
            chk("sout_l", sout_l, m_q / (2 ** (W - 1)));
            chk("sout_valid", sout_valid, m_rem > 0);
            chk("busy", busy, (m_rem > 0) || m_done);
            chk("done", done, m_done);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input bit d, input logic [W-1:0] p, input bit s_in, input bit stall,
                         input bit noise, output int nvalid, output int nbusy, output int ndone,
                         output logic [W-1:0] qend);
        bit stalled = 0;
        nvalid = 0; nbusy = 0; ndone = 0;
        obs.delete();
        en = 1; start = 1; dir = d; pin = p; mode = 2'd0; sin_r = s_in; sin_l = s_in;
        step();
        start = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) nbusy++;
            if (sout_valid) begin
                nvalid++;
                obs.push_back(d ? sout_l : sout_r);
            end
            if (done) ndone++;
            if (!busy) break;
            en = 1;
            if (stall && !stalled && nvalid == 3) begin
                en = 0;
                stalled = 1;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                mode  = 2'b11;
                pin   = W'($urandom);
                dir   = 1'($urandom);
            end
            step();
        end
        start = 0; mode = 2'd0; en = 1;
        qend = q;
        chk("burst_returns_idle", busy, 0);
    endtask

    task automatic chk_bits(input string nm, input bit exp[$]);
        chk({nm, "_len"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_bit%0d", nm, i), obs[i], exp[i]);
        end
    endtask

    int nv, nb, nd;
    logic [W-1:0] qe;

    initial begin
        rst = 1; en = 0; mode = 0; sin_r = 0; sin_l = 0; pin = 0; start = 0; dir = 0;
        #3 rst = 0;
        #1 chk_en = 1;
        #16;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", sout_valid, 0);
        #3 rst = 1;

        // Manual load then shift right
        en = 1; mode = 2'b11; pin = 8'hA5;
        step();
        chk("load_a5", q, 8'hA5);
        mode = 2'b01; sin_r = 1;
        step();
        chk("shr_q", q, 8'hD2);
        chk("shr_sout_r", sout_r, 0);

        // Manual shift left twice
        mode = 2'b11; pin = 8'hA5;
        step();
        mode = 2'b10; sin_l = 0;
        step();
        chk("shl1_q", q, 8'h4A);
        step();
        chk("shl2_q", q, 8'h94);
        chk("shl2_sout_l", sout_l, 1);
        mode = 2'b00;
        step();

        // Right burst
        burst(0, 8'hB4, 1, 0, 0, nv, nb, nd, qe);
        chk("rburst_valid", nv, 8);
        chk("rburst_busy", nb, 9);
        chk("rburst_done", nd, 1);
        chk("rburst_q", qe, 8'hFF);
        chk_bits("rburst", '{0, 0, 1, 0, 1, 1, 0, 1});

        // Left burst with a stall on the 3rd shift cycle; starts right after the previous DONE
        burst(1, 8'hB4, 0, 1, 0, nv, nb, nd, qe);
        chk("lburst_valid", nv, 9);
        chk("lburst_busy", nb, 10);
        chk("lburst_done", nd, 1);
        chk("lburst_q", qe, 8'h00);
        chk_bits("lburst", '{1, 0, 1, 1, 1, 0, 1, 0, 0});

        // Burst with start/mode/pin/dir noise while busy
        burst(0, 8'h5A, 0, 0, 1, nv, nb, nd, qe);
        chk("nburst_valid", nv, 8);
        chk("nburst_busy", nb, 9);
        chk("nburst_done", nd, 1);
        chk("nburst_q", qe, 8'h00);
        chk_bits("nburst", '{0, 1, 0, 1, 1, 0, 1, 0});

        // Reset in the 4th shift cycle
        en = 1; start = 1; dir = 0; pin = 8'hB4;
        step();
        start = 0;
        step(); step(); step();
        chk("pre_rst_valid", sout_valid, 1);
        #2 rst = 0;
        #1;
        chk("midrst_q", q, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_valid", sout_valid, 0);
        @(negedge clk);
        rst = 1;
        mode = 2'b11; pin = 8'h3C;
        step();
        chk("postrst_q", q, 8'h3C);
        chk("postrst_busy", busy, 0);
        chk("postrst_done", done, 0);
        mode = 2'b00;

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 7) != 0);
            mode  = 2'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            pin   = W'($urandom);
            start = ($urandom_range(0, 5) == 0);
            dir   = 1'($urandom);
            step();
        end
        rst = 1; start = 0; en = 1;
        step();
        @(negedge clk);
        #1 chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
